// File: rtl/proc_core_param.sv
`default_nettype none
// ============================================================================
// Module  : proc_core_param
// Brief   : Parametrised multicycle core (mv/mvi/add/sub/and/or/xor/mvnz)
//           with a T0..T3 step FSM and a single shared bus.
// Rev     : 1.0 - initial release
// ============================================================================
module proc_core_param #(
    parameter int DATA_W = 9,
    parameter int NREGS  = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Run,
    input  logic [DATA_W-1:0]       DIN,
    output logic                    Done,
    output logic [DATA_W-1:0]       BusWires,
    output logic [NREGS*DATA_W-1:0] R_out,
    output logic [DATA_W-1:0]       RA_out,
    output logic [DATA_W-1:0]       RG_out,
    output logic [DATA_W-1:0]       IR_out,
    output logic                    Z_out,
    output logic [1:0]              Tstep_state
);

    localparam int REG_AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int RX_MSB = DATA_W - 4;
    localparam int RY_MSB = DATA_W - 4 - REG_AW;

    localparam logic [2:0] c_OP_MV   = 3'd0;
    localparam logic [2:0] c_OP_MVI  = 3'd1;
    localparam logic [2:0] c_OP_ADD  = 3'd2;
    localparam logic [2:0] c_OP_SUB  = 3'd3;
    localparam logic [2:0] c_OP_AND  = 3'd4;
    localparam logic [2:0] c_OP_OR   = 3'd5;
    localparam logic [2:0] c_OP_XOR  = 3'd6;
    localparam logic [2:0] c_OP_MVNZ = 3'd7;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    tstep_t              r_state;
    tstep_t              w_next;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_g;
    logic                r_z;
    logic [DATA_W-1:0]   r_rf [NREGS];

    logic [2:0]          w_op;
    logic [REG_AW-1:0]   w_rx;
    logic [REG_AW-1:0]   w_ry;
    logic [DATA_W-1:0]   w_rx_val;
    logic [DATA_W-1:0]   w_ry_val;
    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_alu;
    logic                w_done;
    logic                w_ir_ld;
    logic                w_a_ld;
    logic                w_g_ld;
    logic                w_rf_we;

    assign w_op = r_ir[DATA_W-1 -: 3];
    assign w_rx = r_ir[RX_MSB -: REG_AW];
    assign w_ry = r_ir[RY_MSB -: REG_AW];

    // Indices past the populated file read as zero (non power-of-two NREGS)
    assign w_rx_val = (int'(w_rx) < NREGS) ? r_rf[w_rx] : '0;
    assign w_ry_val = (int'(w_ry) < NREGS) ? r_rf[w_ry] : '0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_bus   = '0;
        w_done  = 1'b0;
        w_ir_ld = 1'b0;
        w_a_ld  = 1'b0;
        w_g_ld  = 1'b0;
        w_rf_we = 1'b0;
        case (r_state)
            T0: begin
                if (Run) begin
                    w_bus   = DIN;
                    w_ir_ld = 1'b1;
                    w_next  = T1;
                end
            end
            T1: begin
                case (w_op)
                    c_OP_MV: begin
                        w_bus   = w_ry_val;
                        w_rf_we = 1'b1;
                        w_done  = 1'b1;
                        w_next  = T0;
                    end
                    c_OP_MVI: begin
                        w_bus   = DIN;
                        w_rf_we = 1'b1;
                        w_done  = 1'b1;
                        w_next  = T0;
                    end
                    c_OP_MVNZ: begin
                        w_bus   = w_ry_val;
                        w_rf_we = ~r_z;
                        w_done  = 1'b1;
                        w_next  = T0;
                    end
                    default: begin
                        w_bus  = w_rx_val;
                        w_a_ld = 1'b1;
                        w_next = T2;
                    end
                endcase
            end
            T2: begin
                w_bus  = w_ry_val;
                w_g_ld = 1'b1;
                w_next = T3;
            end
            T3: begin
                w_bus   = r_g;
                w_rf_we = 1'b1;
                w_done  = 1'b1;
                w_next  = T0;
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

    // The second ALU operand is always whatever is on the bus in T2 (Ry)
    always_comb begin
        w_alu = w_bus;
        case (w_op)
            c_OP_ADD: w_alu = r_a + w_bus;
            c_OP_SUB: w_alu = r_a - w_bus;
            c_OP_AND: w_alu = r_a & w_bus;
            c_OP_OR:  w_alu = r_a | w_bus;
            c_OP_XOR: w_alu = r_a ^ w_bus;
            default:  w_alu = w_bus;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            r_z  <= 1'b1;
            for (int k = 0; k < NREGS; k++) begin
                r_rf[k] <= '0;
            end
        end else begin
            if (w_ir_ld) begin
                r_ir <= DIN;
            end
            if (w_a_ld) begin
                r_a <= w_bus;
            end
            if (w_g_ld) begin
                r_g <= w_alu;
                r_z <= (w_alu == '0);
            end
            // Writes to an unpopulated index match no k and are dropped
            for (int k = 0; k < NREGS; k++) begin
                if (w_rf_we && (int'(w_rx) == k)) begin
                    r_rf[k] <= w_bus;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_rout
            assign R_out[k*DATA_W +: DATA_W] = r_rf[k];
        end
    endgenerate

    assign Done        = w_done;
    assign BusWires    = w_bus;
    assign RA_out      = r_a;
    assign RG_out      = r_g;
    assign IR_out      = r_ir;
    assign Z_out       = r_z;
    assign Tstep_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_proc_core_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_proc_core_param
// Brief   : Scoreboard bench for proc_core_param (default 9-bit/8-reg core
//           plus a 16-bit/16-reg instance).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_proc_core_param;

    localparam int W  = 9;
    localparam int N  = 8;
    localparam int W2 = 16;
    localparam int N2 = 16;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           Run;
    logic [W-1:0]   DIN;
    logic           Done;
    logic [W-1:0]   BusWires;
    logic [N*W-1:0] R_out;
    logic [W-1:0]   RA_out, RG_out, IR_out;
    logic           Z_out;
    logic [1:0]     Tstep_state;

    logic             Run16;
    logic [W2-1:0]    DIN16;
    logic             Done16;
    logic [W2-1:0]    Bus16;
    logic [N2*W2-1:0] R16;
    logic [W2-1:0]    RA16, RG16, IR16;
    logic             Z16;
    logic [1:0]       T16;

    proc_core_param #(.DATA_W(W), .NREGS(N)) u_dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .Done(Done),
        .BusWires(BusWires), .R_out(R_out), .RA_out(RA_out), .RG_out(RG_out),
        .IR_out(IR_out), .Z_out(Z_out), .Tstep_state(Tstep_state)
    );

    proc_core_param #(.DATA_W(W2), .NREGS(N2)) u_wide (
        .Clock(Clock), .Reset(Reset), .Run(Run16), .DIN(DIN16), .Done(Done16),
        .BusWires(Bus16), .R_out(R16), .RA_out(RA16), .RG_out(RG16),
        .IR_out(IR16), .Z_out(Z16), .Tstep_state(T16)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int           dcyc;
        logic [W-1:0] bus;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;

    logic [W-1:0] mr [N];
    logic [W-1:0] ma, mg;
    logic         mz;

    // Each Done pulse retires exactly one pending expectation
    always @(negedge Clock) begin
        if (Reset === 1'b0 && Done === 1'b1) begin
            done_cnt++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got Done=1 want no pending instruction", cyc);
            end else begin
                e_mon = sbq.pop_front();
                if (cyc !== e_mon.dcyc || BusWires !== e_mon.bus) begin
                    errors++;
                    $display("FAIL done_scoreboard got cyc=%0d bus=%h want cyc=%0d bus=%h",
                             cyc, BusWires, e_mon.dcyc, e_mon.bus);
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < N; k++) mr[k] = '0;
        ma = '0;
        mg = '0;
        mz = 1'b1;
    endtask

    // Drive one instruction from a T0 negedge; returns at the next T0 negedge
    task automatic issue(input logic [2:0] op, input int rx, input int ry,
                         input logic [W-1:0] imm, input bit hold);
        logic [W-1:0] ins, bus, a, b, r;
        int lat, guard;
        exp_t e;
        ins = {op, 3'(rx), 3'(ry)};
        lat = 2;
        case (op)
            3'd0: begin bus = mr[ry]; mr[rx] = bus; end
            3'd1: begin bus = imm; mr[rx] = imm; end
            3'd7: begin bus = mr[ry]; if (!mz) mr[rx] = bus; end
            default: begin
                lat = 4;
                a = mr[rx];
                b = mr[ry];
                case (op)
                    3'd2:    r = a + b;
                    3'd3:    r = a - b;
                    3'd4:    r = a & b;
                    3'd5:    r = a | b;
                    default: r = a ^ b;
                endcase
                ma = a;
                mg = r;
                mz = (r == '0);
                mr[rx] = r;
                bus = r;
            end
        endcase
        e.dcyc = cyc + lat - 1;
        e.bus  = bus;
        sbq.push_back(e);
        Run = 1'b1;
        DIN = ins;
        @(posedge Clock);
        @(negedge Clock);
        DIN = imm;
        Run = hold;
        guard = 0;
        while (Done !== 1'b1 && guard < 8) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 8) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no Done want Done within 8 cycles ins=%h", ins);
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run = 1'b0;
        DIN = '0;
        Run16 = 1'b0;
        DIN16 = '0;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (R_out !== '0) begin errors++; $display("FAIL rst_regs got %h want 0", R_out); end
        checks++; if (RA_out !== '0 || RG_out !== '0) begin errors++; $display("FAIL rst_ag got A=%h G=%h want 0", RA_out, RG_out); end
        checks++; if (IR_out !== '0) begin errors++; $display("FAIL rst_ir got %h want 0", IR_out); end
        checks++; if (Z_out !== 1'b1) begin errors++; $display("FAIL rst_z got %b want 1", Z_out); end
        checks++; if (Tstep_state !== 2'd0) begin errors++; $display("FAIL rst_tstep got %0d want 0", Tstep_state); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", Done); end
        checks++; if (BusWires !== '0) begin errors++; $display("FAIL rst_bus got %h want 0", BusWires); end
    endtask

    task automatic test_mvi();
        issue(3'd1, 0, 0, 9'd5, 1'b0);
        issue(3'd1, 1, 0, 9'd3, 1'b0);
        checks++; if (R_out[0*W +: W] !== 9'd5) begin errors++; $display("FAIL mvi_r0 got %h want 005", R_out[0*W +: W]); end
        checks++; if (R_out[1*W +: W] !== 9'd3) begin errors++; $display("FAIL mvi_r1 got %h want 003", R_out[1*W +: W]); end
        checks++; if (Z_out !== 1'b1 || RG_out !== '0) begin errors++; $display("FAIL mvi_zg got Z=%b G=%h want Z=1 G=0", Z_out, RG_out); end
    endtask

    task automatic test_sub();
        issue(3'd1, 0, 0, 9'd3, 1'b0);
        issue(3'd1, 1, 0, 9'd5, 1'b0);
        issue(3'd3, 0, 1, 9'd0, 1'b0);
        checks++; if (R_out[0*W +: W] !== 9'h1FE) begin errors++; $display("FAIL sub_r0 got %h want 1fe", R_out[0*W +: W]); end
        checks++; if (RG_out !== 9'h1FE) begin errors++; $display("FAIL sub_g got %h want 1fe", RG_out); end
        checks++; if (RA_out !== 9'd3) begin errors++; $display("FAIL sub_a got %h want 003", RA_out); end
        checks++; if (Z_out !== 1'b0) begin errors++; $display("FAIL sub_z got %b want 0", Z_out); end
    endtask

    task automatic test_mvnz();
        issue(3'd1, 3, 0, 9'h055, 1'b0);
        issue(3'd1, 2, 0, 9'h01A, 1'b0);
        issue(3'd6, 2, 2, 9'd0, 1'b0);
        checks++; if (R_out[2*W +: W] !== '0 || Z_out !== 1'b1) begin errors++; $display("FAIL xor_self got R2=%h Z=%b want 000 1", R_out[2*W +: W], Z_out); end
        issue(3'd7, 3, 1, 9'd0, 1'b0);
        checks++; if (R_out[3*W +: W] !== 9'h055) begin errors++; $display("FAIL mvnz_hold got %h want 055", R_out[3*W +: W]); end
        issue(3'd2, 1, 1, 9'd0, 1'b0);
        checks++; if (R_out[1*W +: W] !== 9'd10 || Z_out !== 1'b0) begin errors++; $display("FAIL add_self got R1=%h Z=%b want 00a 0", R_out[1*W +: W], Z_out); end
        issue(3'd7, 3, 1, 9'd0, 1'b0);
        checks++; if (R_out[3*W +: W] !== 9'd10) begin errors++; $display("FAIL mvnz_copy got %h want 00a", R_out[3*W +: W]); end
    endtask

    task automatic test_logic();
        issue(3'd1, 4, 0, 9'h0F3, 1'b0);
        issue(3'd1, 5, 0, 9'h13C, 1'b0);
        issue(3'd4, 4, 5, 9'd0, 1'b0);
        checks++; if (R_out[4*W +: W] !== 9'h030) begin errors++; $display("FAIL and_r4 got %h want 030", R_out[4*W +: W]); end
        issue(3'd1, 6, 0, 9'h101, 1'b0);
        issue(3'd5, 6, 4, 9'd0, 1'b0);
        checks++; if (R_out[6*W +: W] !== 9'h131) begin errors++; $display("FAIL or_r6 got %h want 131", R_out[6*W +: W]); end
        issue(3'd2, 6, 6, 9'd0, 1'b0);
        checks++; if (R_out[6*W +: W] !== 9'h062) begin errors++; $display("FAIL add_wrap got %h want 062", R_out[6*W +: W]); end
        issue(3'd0, 7, 6, 9'd0, 1'b0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (R_out[k*W +: W] !== mr[k]) begin errors++; $display("FAIL logic_reg%0d got %h want %h", k, R_out[k*W +: W], mr[k]); end
        end
        checks++; if (RA_out !== ma || RG_out !== mg || Z_out !== mz) begin errors++; $display("FAIL logic_agz got %h %h %b want %h %h %b", RA_out, RG_out, Z_out, ma, mg, mz); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        issue(3'd1, 0, 0, 9'h1FF, 1'b1);
        issue(3'd2, 0, 0, 9'd0, 1'b1);
        issue(3'd0, 1, 0, 9'd0, 1'b0);
        checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", done_cnt - d0); end
        checks++; if (R_out[1*W +: W] !== 9'h1FE) begin errors++; $display("FAIL b2b_r1 got %h want 1fe", R_out[1*W +: W]); end
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL b2b_pending got %0d want 0", sbq.size()); end
    endtask

    task automatic test_reset_mid();
        issue(3'd1, 0, 0, 9'd7, 1'b0);
        issue(3'd1, 1, 0, 9'd2, 1'b0);
        Run = 1'b1;
        DIN = {3'd2, 3'd0, 3'd1};
        @(posedge Clock);
        @(negedge Clock);
        Run = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++; if (Tstep_state !== 2'd2) begin errors++; $display("FAIL mid_t2 got %0d want 2", Tstep_state); end
        Reset = 1'b1;
        #1;
        model_reset();
        checks++; if (R_out !== '0 || RA_out !== '0 || RG_out !== '0 || IR_out !== '0) begin errors++; $display("FAIL mid_rst_state got R=%h A=%h G=%h IR=%h want 0", R_out, RA_out, RG_out, IR_out); end
        checks++; if (Z_out !== 1'b1 || Tstep_state !== 2'd0 || Done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got Z=%b T=%0d D=%b want 1 0 0", Z_out, Tstep_state, Done); end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (Tstep_state !== 2'd0 || BusWires !== '0) begin errors++; $display("FAIL mid_idle got T=%0d bus=%h want 0 0", Tstep_state, BusWires); end
        issue(3'd1, 4, 0, 9'd9, 1'b0);
        checks++; if (R_out[4*W +: W] !== 9'd9 || R_out[0*W +: W] !== '0) begin errors++; $display("FAIL mid_refetch got R4=%h R0=%h want 009 000", R_out[4*W +: W], R_out[0*W +: W]); end
    endtask

    task automatic wide_step(input logic [W2-1:0] ins, input logic [W2-1:0] imm, input int steps);
        Run16 = 1'b1;
        DIN16 = ins;
        @(posedge Clock);
        @(negedge Clock);
        DIN16 = imm;
        Run16 = 1'b0;
        repeat (steps - 1) @(negedge Clock);
    endtask

    task automatic test_wide();
        logic [W2-1:0] ins;
        wide_step({3'd1, 4'd15, 4'd0, 5'd0}, 16'hF0F0, 1);
        checks++; if (Done16 !== 1'b1) begin errors++; $display("FAIL wide_mvi_done got %b want 1", Done16); end
        @(negedge Clock);
        wide_step({3'd1, 4'd14, 4'd0, 5'd0}, 16'h0FF0, 1);
        @(negedge Clock);
        ins = {3'd4, 4'd15, 4'd14, 5'd0};
        wide_step(ins, 16'h0000, 3);
        checks++; if (Done16 !== 1'b1 || Bus16 !== 16'h00F0) begin errors++; $display("FAIL wide_and_t3 got D=%b bus=%h want 1 00f0", Done16, Bus16); end
        @(negedge Clock);
        checks++; if (R16[15*W2 +: W2] !== 16'h00F0) begin errors++; $display("FAIL wide_r15 got %h want 00f0", R16[15*W2 +: W2]); end
        checks++; if (R16[14*W2 +: W2] !== 16'h0FF0 || IR16 !== ins) begin errors++; $display("FAIL wide_r14_ir got %h %h want 0ff0 %h", R16[14*W2 +: W2], IR16, ins); end
        checks++; if (Z16 !== 1'b0 || RG16 !== 16'h00F0 || RA16 !== 16'hF0F0) begin errors++; $display("FAIL wide_zga got Z=%b G=%h A=%h want 0 00f0 f0f0", Z16, RG16, RA16); end
        checks++; if (Done16 !== 1'b0 || T16 !== 2'd0) begin errors++; $display("FAIL wide_idle got D=%b T=%0d want 0 0", Done16, T16); end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_sub();
        test_mvnz();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        repeat (2) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
